output_port_arbiter: RTL and testbench

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

---
 rtl/output_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_output_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//
// Purpose:
//   Per-output-port packet arbiter for a mesh router. Up to PORTS input ports
//   request this output. The arbiter grants one port at a time and holds the
//   grant until the packet is finished. The search order is round-robin,
//   starting from a pointer that moves past the last served port.
//
//   A grant is released for one of three reasons, checked in this order:
//     1. tail  - the granted port marks its last flit (counts a packet)
//     2. abort - the granted port drops its request without a tail
//     3. watchdog - out_busy has been high for TIMEOUT consecutive cycles
//   After any release the arbiter sits in IDLE for at least one cycle.
//
// Parameters:
//   PORTS    number of requesting input ports (local, N, E, S, W)
//   TIMEOUT  consecutive busy cycles tolerated while LOCKED (must be >= 1)
//   CNT_W    width of the saturating completed-packet counter
//
// Ports:
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous active-high reset
//   req          in   [PORTS] request per input port
//   tail         in   [PORTS] last-flit pulse per input port
//   out_busy     in   downstream link cannot accept a flit
//   grant        out  [PORTS] registered one-hot grant, zero when idle
//   grant_valid  out  registered OR of grant
//   grant_idx    out  registered index of the granted port, zero when idle
//   timeout      out  registered one-cycle pulse on watchdog release
//   pkt_count    out  [CNT_W] saturating count of packets ended by tail
// ---------------------------------------------------------------------------
module output_port_arbiter #(
  parameter int PORTS   = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 20,
  localparam int IDX_W  = (PORTS > 1) ? $clog2(PORTS) : 1,
  localparam int WD_W   = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] tail,
  input  logic             out_busy,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout,
  output logic [CNT_W-1:0] pkt_count
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [PORTS-1:0] r_grant;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_timeout;
  logic [CNT_W-1:0] r_pkt_count;
  logic [WD_W-1:0]  r_wd;

  // -------------------------------------------------------------------------
  // Round-robin candidate search
  //
  // Candidate gi is the port at offset gi from the pointer, wrapped modulo
  // PORTS. Offset 0 is the highest priority. The sum needs one extra bit
  // because ptr + offset can reach 2*PORTS-2 before the wrap.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] w_cand_idx [PORTS];
  logic [PORTS-1:0] w_cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_cand
      logic [IDX_W:0] w_sum;
      assign w_sum = {1'b0, r_ptr} + (IDX_W+1)'(gi);
      assign w_cand_idx[gi] = (w_sum >= (IDX_W+1)'(PORTS))
                              ? IDX_W'(w_sum - (IDX_W+1)'(PORTS))
                              : w_sum[IDX_W-1:0];
      assign w_cand_req[gi] = req[w_cand_idx[gi]];
    end
  endgenerate

  // Walk the offsets from last to first, so the lowest set offset is the
  // one that is left in w_pick_idx.
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_found;

  always_comb begin
    w_pick_idx   = '0;
    w_pick_found = |w_cand_req;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        w_pick_idx = w_cand_idx[k];
      end
    end
  end

  logic [PORTS-1:0] w_pick_onehot;
  assign w_pick_onehot = {{(PORTS-1){1'b0}}, 1'b1} << w_pick_idx;

  // -------------------------------------------------------------------------
  // Release causes while LOCKED
  //
  // Only the granted port's tail and req matter. Tails and requests from
  // the other ports are ignored while a packet holds the output.
  // -------------------------------------------------------------------------
  logic            w_locked;
  logic            w_tail_hit;
  logic            w_req_hit;
  logic [WD_W-1:0] w_wd_inc;
  logic            w_wd_expire;
  logic            w_rel_tail;
  logic            w_rel_abort;
  logic            w_rel_wd;
  logic            w_release;

  assign w_locked   = (r_state == S_LOCKED);
  assign w_tail_hit = tail[r_grant_idx];
  assign w_req_hit  = req[r_grant_idx];

  // While LOCKED the watchdog stays below TIMEOUT, so the increment cannot
  // overflow WD_W. Expiry is the busy cycle that would bring it to TIMEOUT.
  assign w_wd_inc    = r_wd + WD_W'(1);
  assign w_wd_expire = out_busy && (w_wd_inc >= WD_W'(TIMEOUT));

  // Strict priority: tail, then abort, then watchdog.
  assign w_rel_tail  = w_locked && w_tail_hit;
  assign w_rel_abort = w_locked && !w_tail_hit && !w_req_hit;
  assign w_rel_wd    = w_locked && !w_tail_hit && w_req_hit && w_wd_expire;
  assign w_release   = w_rel_tail || w_rel_abort || w_rel_wd;

  // On release, the pointer moves to the port after the one just served.
  logic [IDX_W-1:0] w_ptr_after;
  assign w_ptr_after = (r_grant_idx == IDX_W'(PORTS - 1))
                       ? '0
                       : r_grant_idx + IDX_W'(1);

  logic w_pkt_sat;
  assign w_pkt_sat = &r_pkt_count;

  // -------------------------------------------------------------------------
  // FSM and output registers
  //
  // grant, grant_valid and grant_idx are always written together, so they
  // cannot disagree with each other.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_timeout     <= 1'b0;
      r_pkt_count   <= '0;
      r_wd          <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!out_busy && w_pick_found) begin
            r_state       <= S_LOCKED;
            r_grant       <= w_pick_onehot;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_pick_idx;
            r_wd          <= '0;
          end
        end
        S_LOCKED: begin
          if (w_release) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_wd          <= '0;
            r_ptr         <= w_ptr_after;
            if (w_rel_tail && !w_pkt_sat) begin
              r_pkt_count <= r_pkt_count + CNT_W'(1);
            end
            if (w_rel_wd) begin
              r_timeout <= 1'b1;
            end
          end else begin
            // The watchdog counts consecutive busy cycles only.
            r_wd <= out_busy ? w_wd_inc : '0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_idx   <= '0;
          r_wd          <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign timeout     = r_timeout;
  assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_port_arbiter
//
// Two arbiters share the clock and reset. dut uses TIMEOUT=4 and an 8-bit
// counter, and it carries the arbitration, abort and watchdog sequences.
// dut_sat uses a 2-bit counter and is used only to show that the counter
// saturates.
//
// Each stimulus cycle is applied on the falling edge. At the same time, the
// outputs expected after the next rising edge are pushed onto a scoreboard
// queue. A monitor pops one entry 2 time units after each rising edge and
// compares it with both DUTs.
// ---------------------------------------------------------------------------
module tb_output_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req, tail;
  logic       out_busy;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       timeout;
  logic [7:0] pkt_count;

  logic [4:0] req2, tail2;
  logic       busy2;
  logic [4:0] grant2;
  logic       grant_valid2;
  logic [2:0] grant_idx2;
  logic       timeout2;
  logic [1:0] pkt_count2;

  always #5 clk = ~clk;

  output_port_arbiter #(.PORTS(5), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .out_busy(out_busy),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .timeout(timeout), .pkt_count(pkt_count)
  );

  output_port_arbiter #(.PORTS(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req(req2), .tail(tail2), .out_busy(busy2),
    .grant(grant2), .grant_valid(grant_valid2), .grant_idx(grant_idx2),
    .timeout(timeout2), .pkt_count(pkt_count2)
  );

  typedef struct {
    string      tag;
    logic [4:0] g;
    logic       to;
    logic [7:0] pk;
    logic [4:0] g2;
    logic [1:0] pk2;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Inputs and expectations for dut_sat are staged here and applied by cyc.
  logic [4:0] nxt_req2  = '0;
  logic [4:0] nxt_tail2 = '0;
  logic [4:0] exp_g2    = '0;
  logic [1:0] exp_pk2   = '0;

  function automatic logic [2:0] oh2idx(input logic [4:0] g);
    oh2idx = '0;
    for (int i = 4; i >= 0; i--) if (g[i]) oh2idx = 3'(i);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one cycle of stimulus and queues the outputs expected after the
  // next rising edge.
  task automatic cyc(input string tag, input logic rst, input logic [4:0] r,
                     input logic [4:0] t, input logic b, input logic [4:0] eg,
                     input logic et, input logic [7:0] ep);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    req      = r;
    tail     = t;
    out_busy = b;
    req2     = nxt_req2;
    tail2    = nxt_tail2;
    e.tag = tag; e.g = eg; e.to = et; e.pk = ep; e.g2 = exp_g2; e.pk2 = exp_pk2;
    sb_q.push_back(e);
  endtask

  // Monitor: compares one scoreboard entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("%0t %s grant=%b idx=%0d to=%b pkt=%0d | sat grant=%b pkt=%0d",
                 $time, e.tag, grant, grant_idx, timeout, pkt_count, grant2, pkt_count2);
        check_val({e.tag, "/grant"},  32'(grant),        32'(e.g));
        check_val({e.tag, "/valid"},  32'(grant_valid),  32'(|e.g));
        check_val({e.tag, "/idx"},    32'(grant_idx),    32'(oh2idx(e.g)));
        check_val({e.tag, "/tmo"},    32'(timeout),      32'(e.to));
        check_val({e.tag, "/pkt"},    32'(pkt_count),    32'(e.pk));
        check_val({e.tag, "/grant2"}, 32'(grant2),       32'(e.g2));
        check_val({e.tag, "/valid2"}, 32'(grant_valid2), 32'(|e.g2));
        check_val({e.tag, "/idx2"},   32'(grant_idx2),   32'(oh2idx(e.g2)));
        check_val({e.tag, "/tmo2"},   32'(timeout2),     32'(1'b0));
        check_val({e.tag, "/pkt2"},   32'(pkt_count2),   32'(e.pk2));
      end
    end
  end

  initial begin
    logic [4:0] oh;
    reset = 1'b1; req = '0; tail = '0; out_busy = 1'b0;
    req2 = '0; tail2 = '0; busy2 = 1'b0;

    // Reset state; requests are ignored while reset is high.
    cyc("rst0", 1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0);
    cyc("rst1", 1, 5'b00110, 5'b00000, 0, 5'b00000, 0, 0);

    // Basic grant, tail release, pointer advance.
    cyc("a_grant1", 0, 5'b00110, 5'b00000, 0, 5'b00010, 0, 0);
    cyc("a_tail1",  0, 5'b00110, 5'b00010, 0, 5'b00000, 0, 1);
    cyc("a_grant2", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 1);
    cyc("a_hold",   0, 5'b11111, 5'b01011, 0, 5'b00100, 0, 1);
    cyc("a_tail2",  0, 5'b00100, 5'b00100, 0, 5'b00000, 0, 2);

    // Round robin over all ports with every request held.
    cyc("b_rst", 1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      oh = 5'b00001 << (i % 5);
      cyc("b_grant", 0, 5'b11111, 5'b00000, 0, oh, 0, 8'(i));
      cyc("b_hold",  0, 5'b11111, 5'b11111 & ~oh, 0, oh, 0, 8'(i));
      cyc("b_tail",  0, 5'b11111, oh, 0, 5'b00000, 0, 8'(i + 1));
    end

    // Abort on port 3; the pointer moves to 4.
    cyc("c_grant3", 0, 5'b01000, 5'b00000, 0, 5'b01000, 0, 6);
    cyc("c_abort",  0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 6);
    cyc("c_ptr4",   0, 5'b11111, 5'b00000, 0, 5'b10000, 0, 6);
    cyc("c_tail4",  0, 5'b11111, 5'b10000, 0, 5'b00000, 0, 7);

    // Watchdog expiry on port 2, then a busy pattern that must not expire.
    cyc("d_grant2", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 7);
    for (int i = 0; i < 3; i++) cyc("d_busy", 0, 5'b00100, 5'b00000, 1, 5'b00100, 0, 7);
    cyc("d_expire",    0, 5'b00100, 5'b00000, 1, 5'b00000, 1, 7);
    cyc("d_idle_busy", 0, 5'b00100, 5'b00000, 1, 5'b00000, 0, 7);
    cyc("d_regrant",   0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 7);
    for (int i = 0; i < 3; i++) cyc("d_busy3a", 0, 5'b00100, 5'b00000, 1, 5'b00100, 0, 7);
    cyc("d_gap", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 7);
    for (int i = 0; i < 3; i++) cyc("d_busy3b", 0, 5'b00100, 5'b00000, 1, 5'b00100, 0, 7);
    cyc("d_quiet", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 7);
    cyc("d_tail",  0, 5'b00100, 5'b00100, 0, 5'b00000, 0, 8);

    // Release priority when causes coincide.
    cyc("e_grant", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 8);
    for (int i = 0; i < 3; i++) cyc("e_busy", 0, 5'b00100, 5'b00000, 1, 5'b00100, 0, 8);
    cyc("e_tail_vs_wd", 0, 5'b00100, 5'b00100, 1, 5'b00000, 0, 9);
    cyc("e_grant", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 9);
    for (int i = 0; i < 3; i++) cyc("e_busy", 0, 5'b00100, 5'b00000, 1, 5'b00100, 0, 9);
    cyc("e_abort_vs_wd", 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 9);
    cyc("e_grant", 0, 5'b00100, 5'b00000, 0, 5'b00100, 0, 9);
    cyc("e_tail_no_req", 0, 5'b00000, 5'b00100, 0, 5'b00000, 0, 10);

    // Reset while locked; the next search starts from port 0.
    cyc("f_grant3", 0, 5'b11111, 5'b00000, 0, 5'b01000, 0, 10);
    cyc("f_reset",  1, 5'b11111, 5'b01000, 1, 5'b00000, 0, 0);
    cyc("f_first",  0, 5'b11111, 5'b00000, 0, 5'b00001, 0, 0);
    cyc("f_tail0",  0, 5'b11111, 5'b00001, 0, 5'b00000, 0, 1);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      nxt_req2 = 5'b00001; nxt_tail2 = 5'b00000;
      exp_g2 = 5'b00001; exp_pk2 = (i > 3) ? 2'd3 : 2'(i);
      cyc("g_grant", 0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1);
      nxt_tail2 = 5'b00001;
      exp_g2 = 5'b00000; exp_pk2 = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
      cyc("g_tail", 0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1);
    end
    nxt_req2 = '0; nxt_tail2 = '0; exp_g2 = '0; exp_pk2 = 2'd3;
    cyc("z_idle", 0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1);

    repeat (3) @(negedge clk);
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
